// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a width helper.
package reset_seq_pkg;

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_SEQ      = 3'd1;
  localparam logic [2:0] ST_DONE     = 3'd2;
  localparam logic [2:0] ST_SW_HOLD  = 3'd3;
  localparam logic [2:0] ST_SW_ACK   = 3'd4;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset release synchroniser: asynchronous assertion, release shifted through a flop chain.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_q << 1;
    end
  end

  assign rst_s = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronised power-on release, staged domain release with a
// programmable hold, and a four-phase software reset handshake.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_out,
  output logic                  sw_rst_ack,
  output logic                  seq_done,
  output logic                  busy
);

  localparam int CW = clog2w(HOLD_CYCLES + 1);
  localparam int IW = clog2w(NUM_STAGES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  logic                  rst_s;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;

  // The state register acts as the last synchroniser flop, so the chain is one shorter.
  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES - 1)
  ) u_rst_sync (
    .clk  (clk),
    .rst  (rst),
    .rst_s(rst_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ack_d   = ack_q;
    done_d  = done_q;
    case (state_q)
      ST_RST_HOLD: begin
        if (!rst_s) begin
          state_d = ST_SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SEQ: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d          = '0;
          stage_d[idx_q] = 1'b0;
          idx_d          = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          state_d = ST_SW_HOLD;
          stage_d = '1;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SW_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SW_ACK;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SW_ACK: begin
        // Stages were re-asserted on leaving DONE and stay that way through re-sequencing.
        if (!sw_rst_req) begin
          state_d = ST_RST_HOLD;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '1;
        ack_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign stage_rst_out = stage_q;
  assign sw_rst_ack    = ack_q;
  assign seq_done      = done_q;
  assign busy          = ~done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing scenarios plus randomized
// reset/request traffic compared against an edge-count based reference model.
module tb_reset_sequencer;

  localparam int NUM  = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 4;

  localparam int M_SEQ    = 0;
  localparam int M_SWHOLD = 1;
  localparam int M_SWACK  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           swRstReq;
  logic [NUM-1:0] stageRstOut;
  logic           swRstAck;
  logic           seqDone;
  logic           busy;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: edges since the last release point, and which phase we are in.
  int mMode;
  int mN;
  int mBase;
  int mM;

  reset_sequencer #(
    .NUM_STAGES (NUM),
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst_req   (swRstReq),
    .stage_rst_out(stageRstOut),
    .sw_rst_ack   (swRstAck),
    .seq_done     (seqDone),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic reqVal);
    rst      = rstVal;
    swRstReq = reqVal;
  endtask

  task automatic modelReset();
    mMode = M_SEQ;
    mBase = SYNC;
    mN    = 0;
    mM    = 0;
  endtask

  // Stage k is released once base + (k+1)*HOLD edges have passed since the release point.
  function automatic int releasedCount();
    int c;
    if (mMode != M_SEQ || mN < mBase) return 0;
    c = (mN - mBase) / HOLD;
    return (c > NUM) ? NUM : c;
  endfunction

  function automatic logic [31:0] modelStage();
    int full;
    full = (1 << NUM) - 1;
    return 32'(full & ~((1 << releasedCount()) - 1));
  endfunction

  function automatic logic [31:0] modelDone();
    return (mMode == M_SEQ && releasedCount() == NUM) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] modelAck();
    return (mMode == M_SWACK) ? 32'd1 : 32'd0;
  endfunction

  task automatic modelEdge(input logic rIn, input logic qIn);
    if (rIn) begin
      modelReset();
      return;
    end
    case (mMode)
      M_SEQ: begin
        if (releasedCount() == NUM && qIn) begin
          mMode = M_SWHOLD;
          mM    = 0;
        end else begin
          mN++;
        end
      end
      M_SWHOLD: begin
        mM++;
        if (mM >= HOLD) mMode = M_SWACK;
      end
      default: begin
        if (!qIn) begin
          mMode = M_SEQ;
          mBase = 1;
          mN    = 0;
        end
      end
    endcase
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_stage"}, 32'(stageRstOut), modelStage());
    checkOutput({tag, "_ack"}, 32'(swRstAck), modelAck());
    checkOutput({tag, "_done"}, 32'(seqDone), modelDone());
    checkOutput({tag, "_busy"}, 32'(busy), 32'(modelDone() == 32'd0));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge(rst, swRstReq);
    @(negedge clk);
    checkModel("cyc");
  endtask

  // Asynchronous reset pulse launched between edges; released with the request low.
  task automatic pulseReset(input int holdEdges);
    #2;
    applyStimulus(1'b1, swRstReq);
    modelReset();
    #1;
    checkOutput("async_stage", 32'(stageRstOut), 32'h7);
    checkOutput("async_ack", 32'(swRstAck), 32'h0);
    checkOutput("async_done", 32'(seqDone), 32'h0);
    checkOutput("async_busy", 32'(busy), 32'h1);
    repeat (holdEdges) stepCycle();
    applyStimulus(1'b0, 1'b0);
  endtask

  // Runs edges E1..E20 after a reset release, checking the fixed power-on timeline.
  task automatic runPowerOn(input logic reqFromE3);
    for (int e = 1; e <= 20; e++) begin
      if (reqFromE3 && e == 3) applyStimulus(1'b0, 1'b1);
      stepCycle();
      if (e == 5)  checkOutput("po_E5_stage", 32'(stageRstOut), 32'h7);
      if (e == 6)  checkOutput("po_E6_stage", 32'(stageRstOut), 32'h6);
      if (e == 10) checkOutput("po_E10_stage", 32'(stageRstOut), 32'h4);
      if (e == 13) checkOutput("po_E13_done", 32'(seqDone), 32'h0);
      if (e == 14) checkOutput("po_E14_stage", 32'(stageRstOut), 32'h0);
      if (e == 14) checkOutput("po_E14_done", 32'(seqDone), 32'h1);
      if (reqFromE3 && e == 15) checkOutput("early_E15_stage", 32'(stageRstOut), 32'h7);
      if (reqFromE3 && e == 15) checkOutput("early_E15_done", 32'(seqDone), 32'h0);
      if (reqFromE3 && e == 18) checkOutput("early_E18_ack", 32'(swRstAck), 32'h0);
      if (reqFromE3 && e == 19) checkOutput("early_E19_ack", 32'(swRstAck), 32'h1);
      if (!reqFromE3 && e == 20) checkOutput("po_E20_done", 32'(seqDone), 32'h1);
    end
  endtask

  task automatic runSoftwareReset();
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("sw_S_stage", 32'(stageRstOut), 32'h7);
    checkOutput("sw_S_done", 32'(seqDone), 32'h0);
    repeat (3) stepCycle();
    checkOutput("sw_S3_ack", 32'(swRstAck), 32'h0);
    stepCycle();
    checkOutput("sw_S4_ack", 32'(swRstAck), 32'h1);
    repeat (3) stepCycle();
    checkOutput("sw_hold_ack", 32'(swRstAck), 32'h1);
    checkOutput("sw_hold_stage", 32'(stageRstOut), 32'h7);
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkOutput("sw_A_ack", 32'(swRstAck), 32'h0);
    for (int a = 1; a <= 13; a++) begin
      stepCycle();
      if (a == 4)  checkOutput("sw_A4_stage", 32'(stageRstOut), 32'h7);
      if (a == 5)  checkOutput("sw_A5_stage", 32'(stageRstOut), 32'h6);
      if (a == 9)  checkOutput("sw_A9_stage", 32'(stageRstOut), 32'h4);
      if (a == 13) checkOutput("sw_A13_stage", 32'(stageRstOut), 32'h0);
      if (a == 13) checkOutput("sw_A13_done", 32'(seqDone), 32'h1);
    end
  endtask

  initial begin
    modelReset();
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("rst_stage", 32'(stageRstOut), 32'h7);
    checkOutput("rst_ack", 32'(swRstAck), 32'h0);
    checkOutput("rst_done", 32'(seqDone), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);

    // Power-on
    repeat (3) stepCycle();
    applyStimulus(1'b0, 1'b0);
    runPowerOn(1'b0);

    // Abort mid-sequence once stage 0 is out of reset
    pulseReset(2);
    for (int e = 1; e <= 7; e++) stepCycle();
    checkOutput("abort_E7_stage", 32'(stageRstOut), 32'h6);
    pulseReset(2);
    runPowerOn(1'b0);

    // Software handshake from DONE
    runSoftwareReset();

    // Request raised early in the power-on sequence
    pulseReset(3);
    runPowerOn(1'b1);
    applyStimulus(1'b0, 1'b0);
    repeat (16) stepCycle();

    // Sub-cycle glitch while idle
    pulseReset(0);
    runPowerOn(1'b0);

    // Reset arriving during the acknowledge phase
    applyStimulus(1'b0, 1'b1);
    repeat (6) stepCycle();
    checkOutput("swack_pre_ack", 32'(swRstAck), 32'h1);
    pulseReset(2);
    runPowerOn(1'b0);

    // Randomized resets and request toggling
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        pulseReset(int'($urandom_range(0, 2)));
      end else if (r < 15) begin
        applyStimulus(1'b0, ~swRstReq);
      end
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller for the design's flip-flop datapaths.
- Takes the raw asynchronous reset, synchronises its release, then releases NUM_STAGES downstream reset domains one at a time, in order, spaced by a programmable hold time.
- Also supports a software-requested reset with a four-phase req/ack handshake.
- Every flop domain in the design takes its reset from one of this block's outputs.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (>=1).
- SYNC_STAGES, 2, synchroniser depth for reset release (>=2).
- HOLD_CYCLES, 4, clock edges between successive stage releases (>=1). Counter width is clog2(HOLD_CYCLES+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high. Assertion takes effect immediately; release is synchronised internally.
- sw_rst_req  input  1  software reset request, synchronous to clk, level.
- stage_rst_out  output  NUM_STAGES  per-domain reset, active-high. Bit k feeds domain k.
- sw_rst_ack  output  1  software reset acknowledge.
- seq_done  output  1  high when all stages are released and the block is idle.
- busy  output  1  inverse of seq_done.

Behaviour:
- Reset values while rst=1: stage_rst_out = all ones, sw_rst_ack=0, seq_done=0, busy=1, FSM=RST_HOLD, hold counter=0, stage index=0.
  - Outputs follow rst asynchronously, with no clock edge required.
- Synchroniser (async set, sync clear):
  - Internal rst_s deasserts at edge E(SYNC_STAGES). E1 is the first rising edge that samples rst=0.
  - A rst glitch shorter than one period still forces the full reset and the full re-sequence.
- FSM states: RST_HOLD, SEQ, DONE, SW_HOLD, SW_ACK.
- RST_HOLD:
  - Entered on rst, or from SW_ACK.
  - When rst_s=0, go to SEQ with counter=0 and index=0.
- SEQ:
  - The counter increments each edge.
  - When it reaches HOLD_CYCLES, clear stage_rst_out[index], reset the counter and increment the index.
  - On releasing the last stage, go to DONE on the same edge.
  - Power-on timing: stage k releases at edge E(SYNC_STAGES + (k+1)*HOLD_CYCLES).
  - Release order is strictly 0 to NUM_STAGES-1. A released bit never re-asserts except through rst or a software reset.
- DONE:
  - seq_done=1, busy=0, stage_rst_out=0.
  - sw_rst_req=1 sampled at an edge gives SW_HOLD. stage_rst_out becomes all ones at that same edge, and seq_done drops.
- SW_HOLD: count HOLD_CYCLES edges, then go to SW_ACK with sw_rst_ack=1.
- SW_ACK:
  - sw_rst_ack stays 1 and stages stay asserted while sw_rst_req=1.
  - sw_rst_req sampled 0 clears sw_rst_ack at that edge and enters RST_HOLD. rst_s is already 0, so the block passes through RST_HOLD for one edge into SEQ.
  - Stage k then releases (k+1)*HOLD_CYCLES+1 edges after the ack drop.
- sw_rst_req outside DONE:
  - Ignored while in RST_HOLD or SEQ.
  - If still high on entering DONE, it is taken on the first DONE edge, so seq_done is high for exactly one cycle.
- rst asserted in any state aborts immediately to the reset values; a software handshake in progress is discarded (ack drops).
- All FSM outputs are registered, with no combinational path from sw_rst_req to any output.

Decomposition:
- Package reset_seq_pkg holds:
  - the FSM state encoding (localparams / enum);
  - a clog2 helper for the counter and index widths.
- Sub-module rst_sync:
  - Parameter SYNC_STAGES; ports clk, rst, rst_s.
  - An async-assert, sync-deassert flop chain, instantiated once.
- The sequencer FSM, counter and output register live in reset_sequencer.

Test Plan:
(NUM_STAGES=3, SYNC_STAGES=2, HOLD_CYCLES=4; E1 = first edge sampling rst=0)
1. Power-on: rst=1 for 3 cycles, then rst=0.
   - stage_rst_out=111 through E5, 110 at E6, 100 at E10, 000 at E14.
   - seq_done=1 at E14.
2. Mid-sequence abort: assert rst 2ns after E7 (stage_rst_out=110).
   - stage_rst_out=111 and seq_done=0 immediately, before the next edge.
   - After release, the full timing of test 1 repeats.
3. Software reset: in DONE, sw_rst_req=1 sampled at edge S.
   - 111 at S, sw_rst_ack=1 at S+4; ack holds while req stays high for 3 more cycles.
   - Drop req, sampled at edge A: ack=0 at A, stages release at A+5 (110), A+9 (100), A+13 (000, seq_done=1).
4. Early request: sw_rst_req=1 from E3 onward.
   - Ignored during the power-on sequence.
   - seq_done is high for one cycle at E14; stage_rst_out=111 at E15; ack at E19.
5. Glitch: 1ns rst pulse between edges while in DONE.
   - Outputs go to 111 asynchronously, and the full power-on sequence re-runs.
6. rst during SW_ACK: sw_rst_ack=0 and stages=111 asynchronously.
   - After rst release, the power-on timing applies and sw_rst_req (held 0) causes no further activity.
